// File: rtl/overlay_pkg.sv
// Shared definitions for the overlay mixer: default video timing, overlay
// window placement, colour constants, pixel width and counter type.
// No ports; imported by video_timing_gen and overlay_mixer.
package overlay_pkg;

  localparam int PIX_W = 24;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int OVL_X_D = 288;
  localparam int OVL_Y_D = 208;
  localparam int OVL_W_D = 64;
  localparam int OVL_H_D = 64;

  localparam logic [PIX_W-1:0] KEY_COLOR_D = 24'hFF00FF;
  localparam logic [PIX_W-1:0] BG_COLOR_D  = 24'h000000;

  // Counter width is fixed; 12 bits covers totals up to 4095.
  typedef logic [11:0] cnt_t;

  function automatic int span_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_D = span_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
  localparam int V_TOTAL_D = span_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters and their decodes.
// Ports:
//   clock, reset    pixel clock, synchronous active-high reset
//   active          counters inside the visible area
//   hsync_n/vsync_n sync decodes, active low, unregistered
//   in_window       counters inside the overlay window
//   at_origin       counters at (0,0)
module video_timing_gen
  import overlay_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int OVL_X    = OVL_X_D,
  parameter int OVL_Y    = OVL_Y_D,
  parameter int OVL_W    = OVL_W_D,
  parameter int OVL_H    = OVL_H_D
) (
  input  logic clock,
  input  logic reset,
  output logic active,
  output logic hsync_n,
  output logic vsync_n,
  output logic in_window,
  output logic at_origin
);

  localparam cnt_t H_LAST  = cnt_t'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam cnt_t V_LAST  = cnt_t'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SS    = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SE    = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_SS    = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SE    = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t WIN_X0  = cnt_t'(OVL_X);
  localparam cnt_t WIN_X1  = cnt_t'(OVL_X + OVL_W);
  localparam cnt_t WIN_Y0  = cnt_t'(OVL_Y);
  localparam cnt_t WIN_Y1  = cnt_t'(OVL_Y + OVL_H);

  // A window reaching outside the visible area would request pixels
  // that are never displayed; refuse to elaborate.
  if ((OVL_X + OVL_W > H_ACTIVE) || (OVL_Y + OVL_H > V_ACTIVE) ||
      (OVL_W < 1) || (OVL_H < 1) || (OVL_X < 0) || (OVL_Y < 0)) begin : g_bad_window
    $error("overlay window does not fit inside the active area");
  end

  cnt_t h_count;
  cnt_t v_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + cnt_t'(1);
    end else begin
      h_count <= h_count + cnt_t'(1);
    end
  end

  assign active    = (h_count < H_ACT) && (v_count < V_ACT);
  assign hsync_n   = !((h_count >= H_SS) && (h_count < H_SE));
  assign vsync_n   = !((v_count >= V_SS) && (v_count < V_SE));
  assign in_window = (h_count >= WIN_X0) && (h_count < WIN_X1) &&
                     (v_count >= WIN_Y0) && (v_count < WIN_Y1);
  assign at_origin = (h_count == '0) && (v_count == '0);

endmodule

// File: rtl/overlay_mixer.sv
// Composites a streamed overlay window onto a flat background and emits
// registered video with syncs. The mixer is the timing master: the raster
// never stalls, a missing overlay pixel is shown as background and latched
// in the sticky underrun flag until the next frame start.
// Ports:
//   clock, reset         pixel clock, synchronous active-high reset
//   dataInput/dataValid  overlay pixel stream from upstream
//   dataReady            pixel accepted this cycle (raster inside window)
//   frameStart           one-cycle pulse at raster origin
//   rgbOutput, hsync, vsync, de   registered video, syncs active low
//   underrun             sticky missed-pixel flag for the current frame
module overlay_mixer
  import overlay_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int OVL_X    = OVL_X_D,
  parameter int OVL_Y    = OVL_Y_D,
  parameter int OVL_W    = OVL_W_D,
  parameter int OVL_H    = OVL_H_D,
  parameter logic [PIX_W-1:0] KEY_COLOR = KEY_COLOR_D,
  parameter logic [PIX_W-1:0] BG_COLOR  = BG_COLOR_D
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] dataInput,
  input  logic             dataValid,
  output logic             dataReady,
  output logic             frameStart,
  output logic [PIX_W-1:0] rgbOutput,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             underrun
);

  logic active;
  logic hsync_n;
  logic vsync_n;
  logic in_window;
  logic at_origin;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .OVL_X(OVL_X), .OVL_Y(OVL_Y), .OVL_W(OVL_W), .OVL_H(OVL_H)
  ) u_timing (
    .clock     (clock),
    .reset     (reset),
    .active    (active),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .in_window (in_window),
    .at_origin (at_origin)
  );

  // Counters read zero during reset, so the decodes must be masked here
  // or upstream would see a ready/frame pulse while the mixer is held.
  assign dataReady  = in_window && !reset;
  assign frameStart = at_origin && !reset;

  logic             transfer;
  logic [PIX_W-1:0] pix_next;

  assign transfer = dataValid && dataReady;

  always_comb begin
    pix_next = '0;
    if (active) begin
      pix_next = BG_COLOR;
      if (transfer && (dataInput != KEY_COLOR)) pix_next = dataInput;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rgbOutput <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      de        <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      rgbOutput <= pix_next;
      hsync     <= hsync_n;
      vsync     <= vsync_n;
      de        <= active;
      // A miss in the frame-start cycle itself must survive the clear.
      if (in_window && !dataValid) underrun <= 1'b1;
      else if (frameStart)         underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_overlay_mixer.sv
// Directed bench for overlay_mixer using a scaled-down raster (24x17 clocks,
// 4x4 window at (4,3)) so full frames stay short. Expected values come from
// the bench's own raster position model and hand-derived counts.
module tb_overlay_mixer;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int OX = 4, OY = 3, OW = 4, OH = 4;
  localparam int FRAME = HT * VT;  // 408
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam logic [23:0] BG  = 24'h0A0B0C;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] dataInput = '0;
  logic        dataValid = 1'b0;
  logic        dataReady, frameStart, hsync, vsync, de, underrun;
  logic [23:0] rgbOutput;

  overlay_mixer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .OVL_X(OX), .OVL_Y(OY), .OVL_W(OW), .OVL_H(OH),
    .KEY_COLOR(KEY), .BG_COLOR(BG)
  ) dut (
    .clock(clock), .reset(reset), .dataInput(dataInput), .dataValid(dataValid),
    .dataReady(dataReady), .frameStart(frameStart), .rgbOutput(rgbOutput),
    .hsync(hsync), .vsync(vsync), .de(de), .underrun(underrun)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int h = 0, v = 0;
  int cyc = 0;
  int last_fs = -1;
  int mode = 0;
  logic eu = 1'b0;
  int n_de, n_hs, n_vs, n_xfer, n_und, n_fs;

  task automatic check_bit(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d: got %b want %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_pix(string tag, logic [23:0] obs, logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d: got %06h want %06h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cnt(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_de = 0; n_hs = 0; n_vs = 0; n_xfer = 0; n_und = 0; n_fs = 0;
  endtask

  function automatic logic win_at(int x, int y);
    return (x >= OX) && (x < OX + OW) && (y >= OY) && (y < OY + OH);
  endfunction

  // Input pattern for the current raster position.
  task automatic drive();
    case (mode)
      0: begin dataValid = 1'b1; dataInput = 24'h123456; end
      1: begin
        dataValid = 1'b1;
        dataInput = (win_at(h, v) && ((h - OX) % 2 == 0)) ? KEY : 24'h123456;
      end
      default: begin
        dataValid = !(h == 5 && v == 4);
        dataInput = 24'h654321;
      end
    endcase
  endtask

  // One clock: combinational checks at the falling edge, registered
  // checks just after the rising edge, then advance the position model.
  task automatic tick();
    logic win, act, fs, ehs, evs, ede, nu;
    logic [23:0] er;
    drive();
    win = win_at(h, v);
    act = (h < HA) && (v < VA);
    fs  = (h == 0) && (v == 0);
    @(negedge clock);
    check_bit("dataReady", dataReady, reset ? 1'b0 : win);
    check_bit("frameStart", frameStart, reset ? 1'b0 : fs);
    if (frameStart) begin
      n_fs++;
      if (last_fs >= 0) check_cnt("frame_period", cyc - last_fs, FRAME);
      last_fs = cyc;
    end
    if (dataValid && dataReady) n_xfer++;
    if (reset) begin
      er = '0; ehs = 1'b1; evs = 1'b1; ede = 1'b0; nu = 1'b0;
      last_fs = -1;
    end else begin
      ehs = !((h >= HA + HF) && (h < HA + HF + HS));
      evs = !((v >= VA + VF) && (v < VA + VF + VS));
      ede = act;
      if (!act) er = '0;
      else if (win && dataValid && dataInput != KEY) er = dataInput;
      else er = BG;
      nu = (win && !dataValid) ? 1'b1 : (fs ? 1'b0 : eu);
    end
    @(posedge clock);
    #1;
    eu = nu;
    check_pix("rgbOutput", rgbOutput, er);
    check_bit("hsync", hsync, ehs);
    check_bit("vsync", vsync, evs);
    check_bit("de", de, ede);
    check_bit("underrun", underrun, eu);
    if (de) n_de++;
    if (!hsync) n_hs++;
    if (!vsync) n_vs++;
    if (underrun) n_und++;
    cyc++;
    if (reset) begin
      h = 0; v = 0;
    end else if (h == HT - 1) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  initial begin
    // Power-up reset.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Two clean frames, constant overlay colour.
    clear_counts();
    mode = 0;
    repeat (2 * FRAME) tick();
    check_cnt("fs_count_2frames", n_fs, 2);
    check_cnt("xfer_count_2frames", n_xfer, 2 * OW * OH);
    check_cnt("de_count_2frames", n_de, 2 * HA * VA);
    check_cnt("hsync_low_2frames", n_hs, 2 * VT * HS);
    check_cnt("vsync_low_2frames", n_vs, 2 * VS * HT);
    check_cnt("underrun_clean", n_und, 0);

    // Key colour on every second window pixel.
    clear_counts();
    mode = 1;
    repeat (FRAME) tick();
    check_cnt("xfer_count_keyed", n_xfer, OW * OH);

    // Single missing pixel at window position (5,4).
    clear_counts();
    mode = 2;
    repeat (FRAME) tick();
    check_cnt("underrun_high_cycles", n_und, 307);
    check_cnt("xfer_count_miss", n_xfer, OW * OH - 1);

    // Following clean frame: flag must stay low after frame start.
    clear_counts();
    mode = 0;
    repeat (FRAME) tick();
    check_cnt("underrun_next_frame", n_und, 0);

    // Mid-frame reset at (10,8).
    for (int i = 0; i < FRAME && !(h == 10 && v == 8); i++) tick();
    check_cnt("reach_reset_point", (h == 10 && v == 8) ? 1 : 0, 1);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    clear_counts();
    repeat (FRAME) tick();
    check_cnt("fs_count_after_reset", n_fs, 1);
    check_cnt("de_count_after_reset", n_de, HA * VA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
